// File: rtl/bus_cycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_cycle_controller
// Description : 68000 bus-cycle controller. Decodes chip-select regions and
//               inserts per-region wait states before DTACK. Supports
//               single-step gating. Optional BERR path via macro BUS_BERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_controller #(
    parameter int                                ADDR_WIDTH  = 24,
    parameter int                                NUM_REGIONS = 4,
    parameter int                                WAIT_WIDTH  = 4,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAIT = '0,
    parameter logic [NUM_REGIONS-1:0]            REGION_RO   = '0,
    parameter int                                BERR_DELAY  = 2
) (
    input  logic                   MCLK_IN,
    input  logic                   RESET_n_IN,
    input  logic                   RUN_IN,
    input  logic                   AS_IN,
    input  logic                   WR_IN,
    input  logic                   UDS_IN,
    input  logic                   LDS_IN,
    input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
    input  logic                   STEPEN_IN,
    input  logic                   STEP_IN,
    output logic [NUM_REGIONS-1:0] CS,
    output logic                   OE,
    output logic                   WE_U,
    output logic                   WE_L,
    output logic                   DTACK,
    output logic                   BERR,
    output logic                   BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WAIT      = 3'd2,
        ST_STEP_HOLD = 3'd3,
        ST_ACK       = 3'd4,
        ST_ERR_DLY   = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_req_smp;
    logic                    r_step_meta;
    logic                    r_step_sync;
    logic                    r_step_prev;
    logic                    w_step_pulse;
    logic                    r_wr;
    logic                    w_wr_next;
    logic [WAIT_WIDTH-1:0]   r_wait_cnt;
    logic [WAIT_WIDTH-1:0]   w_wait_next;
    logic [NUM_REGIONS-1:0]  w_hit;
    logic [NUM_REGIONS-1:0]  w_sel;
    logic                    w_sel_ro;
    logic [WAIT_WIDTH-1:0]   w_sel_wait;
    logic                    w_bad_access;
    logic [NUM_REGIONS-1:0]  w_cs_next;
    logic                    w_strb_en;
    logic                    w_oe_next;
    logic                    w_we_u_next;
    logic                    w_we_l_next;
    logic                    w_dtack_next;
    logic                    w_berr_next;
    logic                    w_busy_next;

`ifdef BUS_BERR_EN
    localparam logic [7:0] c_err_load = 8'(BERR_DELAY - 1);
    logic [7:0] r_err_cnt;
    logic [7:0] w_err_next;
`else
    logic [7:0] w_unused_cfg;
    assign w_unused_cfg = 8'(BERR_DELAY);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign w_hit[gi] =
                ((ADDR_IN & REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 (REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
        end
    endgenerate

    // Scan downward so the lowest-indexed matching region wins.
    always_comb begin
        w_sel      = '0;
        w_sel_ro   = 1'b0;
        w_sel_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel      = '0;
                w_sel[i]   = 1'b1;
                w_sel_ro   = REGION_RO[i];
                w_sel_wait = REGION_WAIT[i*WAIT_WIDTH +: WAIT_WIDTH];
            end
        end
    end

    assign w_bad_access = ~(|w_hit) | (WR_IN & w_sel_ro);
    assign w_step_pulse = r_step_sync & ~r_step_prev;

    always_comb begin
        w_state_next = r_state;
        w_wr_next    = r_wr;
        w_wait_next  = r_wait_cnt;
        w_cs_next    = CS;
`ifdef BUS_BERR_EN
        w_err_next   = r_err_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_req_smp) w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_wr_next = WR_IN;
                if (w_bad_access) begin
                    w_cs_next = '0;
`ifdef BUS_BERR_EN
                    w_state_next = ST_ERR_DLY;
                    w_err_next   = c_err_load;
`else
                    w_state_next = ST_ACK;
`endif
                end else begin
                    w_state_next = ST_WAIT;
                    w_cs_next    = w_sel;
                    w_wait_next  = w_sel_wait;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0)
                    w_state_next = STEPEN_IN ? ST_STEP_HOLD : ST_ACK;
                else
                    w_wait_next = r_wait_cnt - WAIT_WIDTH'(1);
            end
            ST_STEP_HOLD: begin
                if (w_step_pulse) w_state_next = ST_ACK;
            end
            ST_ACK: begin
                w_state_next = ST_ACK;
            end
`ifdef BUS_BERR_EN
            ST_ERR_DLY: begin
                if (r_err_cnt == 8'd0)
                    w_state_next = ST_ERR;
                else
                    w_err_next = r_err_cnt - 8'd1;
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase

        if ((r_state != ST_IDLE && !AS_IN) || !RUN_IN) w_state_next = ST_IDLE;
        if (w_state_next == ST_IDLE) w_cs_next = '0;

        w_strb_en   = |w_cs_next;
        w_oe_next   = w_strb_en & ~w_wr_next;
        w_we_u_next = w_strb_en & w_wr_next & UDS_IN;
        w_we_l_next = w_strb_en & w_wr_next & LDS_IN;
        // An ACK entered straight from DECODE (unmapped, no BERR) waits one edge.
        w_dtack_next = (w_state_next == ST_ACK) && (r_state != ST_DECODE);
`ifdef BUS_BERR_EN
        w_berr_next = (w_state_next == ST_ERR);
`else
        w_berr_next = 1'b0;
`endif
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            r_state     <= ST_IDLE;
            r_req_smp   <= 1'b0;
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
            r_wr        <= 1'b0;
            r_wait_cnt  <= '0;
            CS          <= '0;
            OE          <= 1'b0;
            WE_U        <= 1'b0;
            WE_L        <= 1'b0;
            DTACK       <= 1'b0;
            BERR        <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_smp   <= RUN_IN & AS_IN & (UDS_IN | LDS_IN);
            r_step_meta <= STEP_IN;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
            r_wr        <= w_wr_next;
            r_wait_cnt  <= w_wait_next;
            CS          <= w_cs_next;
            OE          <= w_oe_next;
            WE_U        <= w_we_u_next;
            WE_L        <= w_we_l_next;
            DTACK       <= w_dtack_next;
            BERR        <= w_berr_next;
            BUSY        <= w_busy_next;
        end
    end

`ifdef BUS_BERR_EN
    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) r_err_cnt <= 8'd0;
        else             r_err_cnt <= w_err_next;
    end
`endif

endmodule
`default_nettype wire

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Parametrised 68000 bus-cycle controller that succeeds the fixed-map bus control logic. It decodes the address into `NUM_REGIONS` chip-select regions and inserts a per-region count of wait states before DTACK. It supports single-step gating of DTACK and can raise BERR on unmapped accesses or on writes to read-only regions. It sits between the CPU bus pins and the PROM/SRAM/peripheral chip selects, clocked by the master clock.

## Interface
Parameters:
- `ADDR_WIDTH`, 24: address bus width.
- `NUM_REGIONS`, 4: number of chip-select regions (1..8).
- `WAIT_WIDTH`, 4: width of each region's wait-state count.
- `REGION_BASE`, 0: flattened `NUM_REGIONS*ADDR_WIDTH` base addresses; region i occupies slice i.
- `REGION_MASK`, 0: flattened compare masks. Region i hits when `(ADDR_IN & MASK_i) == (BASE_i & MASK_i)`.
- `REGION_WAIT`, 0: flattened `NUM_REGIONS*WAIT_WIDTH` wait-state counts.
- `REGION_RO`, 0: `NUM_REGIONS` bits; 1 marks the region read-only.
- `BERR_DELAY`, 2: cycles in ERR_DLY before BERR asserts (1..255).

Ports:
- `MCLK_IN`, in, 1: master clock; all state is updated on the rising edge.
- `RESET_n_IN`, in, 1: asynchronous active-low reset.
- `RUN_IN`, in, 1: system running; 0 forces IDLE.
- `AS_IN`, in, 1: address strobe, active high.
- `WR_IN`, in, 1: 1 means write cycle.
- `UDS_IN`, in, 1: upper data strobe, active high.
- `LDS_IN`, in, 1: lower data strobe, active high.
- `ADDR_IN`, in, `ADDR_WIDTH`: CPU address.
- `STEPEN_IN`, in, 1: single-step mode enable.
- `STEP_IN`, in, 1: step button, asynchronous, active high.
- `CS`, out, `NUM_REGIONS`: one-hot chip selects.
- `OE`, out, 1: memory output enable.
- `WE_U`, out, 1: upper-byte write enable.
- `WE_L`, out, 1: lower-byte write enable.
- `DTACK`, out, 1: data transfer acknowledge, active high.
- `BERR`, out, 1: bus error, active high.
- `BUSY`, out, 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered. Every output resets to 0 and the state resets to IDLE.
- `STEP_IN` passes through a 2-flop synchronizer and a rising-edge detector to produce `step_pulse`.
- The state machine has seven states: IDLE, DECODE, WAIT, STEP_HOLD, ACK, ERR_DLY, ERR.
- IDLE:
  - Moves to DECODE when `RUN_IN & AS_IN & (UDS_IN | LDS_IN)`.
- DECODE:
  - Latches `WR_IN` and the hit vector.
  - When several regions match, the lowest index wins.
  - If there is no hit, or a write targets an RO region, the next state is ERR_DLY.
  - Otherwise the next state is WAIT, `CS[i]` is set, and the counter is loaded with `WAIT_i`.
- WAIT:
  - If the counter is 0, moves to STEP_HOLD when `STEPEN_IN` is high, else to ACK.
  - If the counter is nonzero, it decrements by 1.
- STEP_HOLD:
  - Stays here until `step_pulse`, then moves to ACK.
  - A `step_pulse` that arrives before STEP_HOLD is entered is discarded.
- ACK:
  - `DTACK` is 1 and is held until `AS_IN` is low, then IDLE.
- ERR_DLY:
  - Counts `BERR_DELAY` cycles, then moves to ERR.
- ERR:
  - `BERR` is 1 and is held until `AS_IN` is low, then IDLE.
  - `CS` stays 0 throughout an error cycle.
- Strobes while `CS` is nonzero:
  - `OE` = `~wr_latched`.
  - `WE_U` = `wr_latched & UDS_IN`.
  - `WE_L` = `wr_latched & LDS_IN`.
  - All three are registered.
- Abort: `AS_IN` low in any non-IDLE state returns to IDLE on the next edge. `CS`, `OE`, `WE_*`, `DTACK` and `BERR` all drop together.
- `RUN_IN` low in any state forces IDLE on the next edge with all outputs cleared.
- A new cycle is accepted only after passing through IDLE. Back-to-back cycles need `AS_IN` low for at least 1 sampled edge.

## Timing
- Strobes are first sampled true at edge n:
  - DECODE at n+1.
  - `CS`/`OE` valid after edge n+2.
  - `DTACK` valid after edge n+3+W, where W is the region's wait count.
- Added latency:
  - Single-step adds the `step_pulse` latency, 2-3 cycles after the `STEP_IN` rise.
  - Error path: `BERR` asserts after edge n+2+`BERR_DELAY`.
- Release: `DTACK`/`BERR`/`CS` deassert on the first edge after `AS_IN` is sampled low.
- Reset mid-cycle clears all outputs immediately (asynchronous). The state returns to IDLE.

## Configuration
- `BUS_BERR_EN` defined: the ERR_DLY/ERR path exists as described above.
- `BUS_BERR_EN` undefined:
  - `BERR` is tied to 0 and the ERR states are removed.
  - Unmapped accesses and RO-region writes go DECODE -> ACK with `CS`=0, completing with `DTACK` at n+3.
  - RO-region writes assert no `WE_*`.

## Test plan
Bench setup for all scenarios:
- Region0: base 0x000000, mask 0xF80000, wait 2, RO.
- Region1: base 0x080000, mask 0xF80000, wait 0.

Scenarios:
- Read at 0x000100 -> `CS`=0001 and `OE`=1 from n+2; `DTACK` at n+5; all outputs clear 1 cycle after `AS_IN` drops.
- Write at 0x080002 with only UDS -> `CS`=0010, `WE_U`=1, `WE_L`=0; `DTACK` at n+3.
- Read at 0x200000 with `BUS_BERR_EN`, `BERR_DELAY`=2 -> `CS`=0000; `BERR` at n+4. Write to 0x000010 -> `BERR`, no `WE_*`.
- Same two accesses without the macro -> `DTACK` at n+3; `BERR` stays 0; `CS`=0000.
- `STEPEN_IN`=1, read 0x080000 -> `DTACK` held low for 20 cycles; `STEP_IN` pulse -> `DTACK` 2-3 cycles later. A pulse during DECODE is ignored.
- `AS_IN` dropped during WAIT, and separately `RESET_n_IN` pulsed in ACK -> IDLE; all outputs 0; the next cycle decodes normally.
